seq_multiplier: RTL and testbench

Multi-cycle 32x32 unsigned shift-and-add multiplier producing a 64-bit product. It sits directly upstream of the 32-bit `rippleadder`: each cycle it drives the adder's `a`/`b` operands from its partial-product register and consumes `sum`/`cout` back into that register. It is the processor's multiply unit and is started by the execute stage with a start/busy/done handshake.

---
 rtl/mul_pkg.sv | 14 +
 rtl/rippleadder.sv | 26 ++
 rtl/seq_multiplier.sv | 77 +++++++
 tb/tb_seq_multiplier.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the multi-cycle multiply unit.
// Width, iteration count and FSM encoding.
package mul_pkg;

  localparam int MUL_W    = 32;
  localparam int MUL_ITER = 32;

  localparam logic [4:0] CNT_LAST = 5'(MUL_ITER - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/rippleadder.sv
// 32-bit ripple-carry adder built from a chain of full adders.
// cout is the carry out of bit 31's full adder.
module rippleadder
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             cin,
  output logic [MUL_W-1:0] sum,
  output logic             cout
);

  logic [MUL_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < MUL_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (a[i] & c[i])
                    | (b[i] & c[i]);
  end

  assign cout = c[MUL_W];

endmodule

// File: rtl/seq_multiplier.sv
// 32x32 unsigned shift-and-add multiplier, one step per cycle.
// Start/busy/done handshake; 64-bit product held in {hi, lo}.
module seq_multiplier
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*MUL_W-1:0]   product
);

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic [MUL_W-1:0] mcand;
  logic [MUL_W-1:0] hi;
  logic [MUL_W-1:0] lo;

  logic [MUL_W-1:0] add_b;
  logic [MUL_W-1:0] add_sum;
  logic             add_cout;

  assign add_b = lo[0] ? mcand : '0;

  rippleadder u_add (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          // 65-bit right shift of {cout, sum, lo}
          {hi, lo} <= {add_cout, add_sum, lo[MUL_W-1:1]};
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == ST_CALC);
  assign done    = (state == ST_DONE);
  assign product = {hi, lo};

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus random checks of seq_multiplier.
// Expected products come from plain 64-bit multiplication.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [63:0] ref_mul(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input logic [31:0] x,
    input logic [31:0] y,
    input string       tag
  );
    logic [63:0] exp;
    int          bad;
    exp = ref_mul(x, y);
    bad = 0;
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    chk({tag, ".busy_e0"}, {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    chk({tag, ".calc"}, 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ".done_e32"}, {63'd0, done}, 64'd1);
    chk({tag, ".busy_e32"}, {63'd0, busy}, 64'd0);
    chk({tag, ".product"}, product, exp);
    @(posedge clk);
    #1;
    chk({tag, ".done_e33"}, {63'd0, done}, 64'd0);
    chk({tag, ".held"}, product, exp);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    int          ndone;
    int          found;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd3, 32'd5, "d3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dmax");
    chk("dmax.lit", product, 64'hFFFF_FFFE_0000_0001);
    run_op(32'h8000_0000, 32'd2, "dmsb");
    run_op(32'd0, 32'h1234_5678, "dzero");
    run_op(32'hFFFF_FFFF, 32'd1, "done1");

    for (int k = 0; k < 8; k++) begin
      rx = $urandom;
      ry = $urandom;
      run_op(rx, ry, $sformatf("rnd%0d", k));
    end

    // start held high across a whole operation
    @(negedge clk);
    a     = 32'd7;
    b     = 32'd6;
    start = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    chk("held.done1", {63'd0, done}, 64'd1);
    chk("held.prod1", product, 64'd42);
    a = 32'd11;
    b = 32'd13;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) found = 1;
    end
    chk("held.done2", 64'(found), 64'd1);
    chk("held.prod2", product, 64'd143);
    start = 1'b0;
    repeat (2) @(posedge clk);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", {63'd0, busy}, 64'd0);
    chk("arst.done", {63'd0, done}, 64'd0);
    chk("arst.product", product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) ndone++;
    end
    chk("arst.nodone", 64'(ndone), 64'd0);
    run_op(32'd9, 32'd9, "arst9x9");

    // start pulses in CALC and in DONE are ignored
    @(negedge clk);
    a     = 32'd100;
    b     = 32'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    chk("ign.done", {63'd0, done}, 64'd1);
    chk("ign.product", product, 64'd20000);
    start = 1'b1;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign.busy_e33", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign.busy_late", {63'd0, busy}, 64'd0);
    chk("ign.held", product, 64'd20000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
